// File: rtl/memory_master.sv
// Single-beat bus initiator for the synchronous write/read memory: sequences
// wr/rd, waits for the write acknowledge (with timeout) and returns a response strobe.
module memory_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 16,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  wr,
  output logic                  rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  response
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (TIMEOUT < 2 || MEM_SIZE < 1) begin : g_param_check
    $error("memory_master: TIMEOUT must be >= 2 and MEM_SIZE >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_RCAP,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Strobes are produced one state early so every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          cmd_ready_d = 1'b0;
          if (cmd_wr) begin
            wr_d    = 1'b1;
            state_d = S_WRITE;
          end else begin
            rd_d    = 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_WRITE: begin
        cnt_d   = '0;
        state_d = S_WRESP;
      end
      S_WRESP: begin
        if (response) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_READ: begin
        state_d = S_RCAP;
      end
      S_RCAP: begin
        rsp_rdata_d = rdata;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_err_d   = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wr        = wr_q;
  assign rd        = rd_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;

endmodule

// File: tb/tb_memory_master.sv
// Directed, table-driven bench for memory_master with a small behavioural
// memory (registered write acknowledge and read data).
module tb_memory_master;

  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_wr = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       wr;
  logic       rd;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata = '0;
  logic       response = 1'b0;
  logic       resp_en = 1'b1;

  logic [7:0] mem [16];

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc_cnt = 0;
  int unsigned rdy_cnt = 0;

  memory_master #(
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8),
    .MEM_SIZE  (16),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_wr   (cmd_wr),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .wr       (wr),
    .rd       (rd),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .response (response)
  );

  always #5 clk = ~clk;

  // Memory: acknowledge and read data appear the cycle after the strobe edge.
  always @(posedge clk) begin
    if (!reset) begin
      response <= 1'b0;
    end else begin
      response <= wr & resp_en;
      if (wr) mem[addr] <= wdata;
      if (rd) rdata <= mem[addr];
    end
  end

  typedef struct {
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
    logic       err;
    logic [7:0] exp_rdata;
    logic       hold;
    logic       no_resp;
  } vec_t;

  vec_t        tbl [40];
  int unsigned n_vec = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic w, input logic [3:0] a, input logic [7:0] d,
                     input logic err, input logic [7:0] exp_rdata,
                     input logic hold, input logic no_resp);
    tbl[n_vec].w         = w;
    tbl[n_vec].a         = a;
    tbl[n_vec].d         = d;
    tbl[n_vec].err       = err;
    tbl[n_vec].exp_rdata = exp_rdata;
    tbl[n_vec].hold      = hold;
    tbl[n_vec].no_resp   = no_resp;
    n_vec++;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_wr"},        32'(wr),        32'd0);
    chk({tag, "_rd"},        32'(rd),        32'd0);
    chk({tag, "_addr"},      32'(addr),      32'd0);
    chk({tag, "_wdata"},     32'(wdata),     32'd0);
  endtask

  // Cycle index 1 is the cycle right after the accepting edge; a normal
  // response occupies cycle 3, a timed-out write cycle TIMEOUT+2.
  task automatic do_cmd(input vec_t v);
    int unsigned rsp_n, wr_n, rd_n, unstable_n, busy_ready_n;
    logic        got, err_s;
    logic [7:0]  rdata_s;
    resp_en   = !v.no_resp;
    cmd_valid = 1'b1;
    cmd_wr    = v.w;
    cmd_addr  = v.a;
    cmd_wdata = v.d;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc_cnt++;
      if (cmd_ready) begin
        rdy_cnt++;
        got = 1'b1;
        break;
      end
    end
    chk("accept", 32'(got), 32'd1);
    if (!got) begin
      cmd_valid = 1'b0;
      return;
    end
    rsp_n = 0; wr_n = 0; rd_n = 0; unstable_n = 0; busy_ready_n = 0;
    err_s = 1'b0; rdata_s = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      cyc_cnt++;
      if (cmd_ready) begin
        rdy_cnt++;
        busy_ready_n++;
      end
      if (n == 1 && !v.hold) cmd_valid = 1'b0;
      cmd_addr  = ~v.a;
      cmd_wdata = ~v.d;
      if (wr) wr_n++;
      if (rd) rd_n++;
      if (addr !== v.a || wdata !== v.d) unstable_n++;
      if (rsp_valid) begin
        rsp_n   = n;
        err_s   = rsp_err;
        rdata_s = rsp_rdata;
        break;
      end
    end
    chk("rsp_cycle", rsp_n, v.err ? 32'(TIMEOUT + 2) : 32'd3);
    chk("rsp_err", 32'(err_s), 32'(v.err));
    chk("rsp_rdata", 32'(rdata_s), 32'(v.exp_rdata));
    chk("wr_pulses", wr_n, v.w ? 32'd1 : 32'd0);
    chk("rd_pulses", rd_n, v.w ? 32'd0 : 32'd1);
    chk("addr_wdata_stable", unstable_n, 32'd0);
    chk("ready_low_busy", busy_ready_n, 32'd0);
    resp_en = 1'b1;
  endtask

  initial begin
    vec_t        v;
    logic        got;
    int unsigned spurious;

    // Write then read, sweep, stale read data, write timeout.
    add(1'b1, 4'd3, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
    add(1'b0, 4'd3, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);
    for (int unsigned a = 0; a < 16; a++)
      add(1'b1, 4'(a), 8'(a) ^ 8'h5A, 1'b0, 8'hA5, 1'b1, 1'b0);
    for (int unsigned a = 0; a < 16; a++)
      add(1'b0, 4'(a), 8'h00, 1'b0, 8'(a) ^ 8'h5A, 1'b1, 1'b0);
    add(1'b1, 4'd3, 8'hA5, 1'b0, 8'h55, 1'b0, 1'b0);
    add(1'b0, 4'd3, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);
    add(1'b1, 4'd4, 8'h11, 1'b0, 8'hA5, 1'b0, 1'b0);
    add(1'b1, 4'd7, 8'h77, 1'b1, 8'hA5, 1'b0, 1'b1);
    add(1'b0, 4'd7, 8'h00, 1'b0, 8'h77, 1'b0, 1'b0);

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b1;

    for (int unsigned i = 0; i < n_vec; i++) begin
      if (i == 2) begin
        cyc_cnt = 0;
        rdy_cnt = 0;
      end
      if (i == 18) begin
        chk("sweep_ready_cycles", rdy_cnt, 32'd16);
        chk("sweep_total_cycles", cyc_cnt, 32'd64);
      end
      do_cmd(tbl[i]);
    end
    cmd_valid = 1'b0;

    // Reset pulse while waiting for the write acknowledge.
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    cmd_addr  = 4'd9;
    cmd_wdata = 8'h3C;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("rst_accept", 32'(got), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_wr_high", 32'(wr), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk_reset_state("midrst");
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) spurious++;
    end
    chk("midrst_no_rsp", spurious, 32'd0);

    v = '{w: 1'b0, a: 4'd9, d: 8'h00, err: 1'b0, exp_rdata: 8'h3C, hold: 1'b0, no_resp: 1'b0};
    do_cmd(v);
    v = '{w: 1'b1, a: 4'd9, d: 8'h42, err: 1'b0, exp_rdata: 8'h3C, hold: 1'b0, no_resp: 1'b0};
    do_cmd(v);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
